// File: rtl/noc_local_ingress_port_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_local_ingress_port_if
// Brief    : PE-to-router local ingress bundle: flit injection, credit return,
//            and crossbar-side valid/ready plus status.
// Revision : 1.0
// ============================================================================
interface noc_local_ingress_port_if #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 8,
    parameter int DEST_W = 4
);
    logic [DATA_W-1:0]          datain;
    logic                       in_valid;
    logic                       ci;
    logic [DATA_W-1:0]          flit_out;
    logic                       flit_valid;
    logic                       flit_ready;
    logic [DEST_W-1:0]          dest;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;

    // Driver side: PE injection and crossbar acceptance.
    modport master (
        output datain, in_valid, flit_ready,
        input  ci, flit_out, flit_valid, dest, count, overflow
    );

    // Ingress port side.
    modport slave (
        input  datain, in_valid, flit_ready,
        output ci, flit_out, flit_valid, dest, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/noc_local_ingress_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_local_ingress_port
// Brief    : Router-side FWFT flit FIFO for a PE injection link, with
//            registered one-pulse-per-drained-flit credit return.
// Revision : 1.0
// ============================================================================
module noc_local_ingress_port #(
    parameter int DATA_W   = 20,
    parameter int DEPTH    = 8,
    parameter int DEST_MSB = 19,
    parameter int DEST_LSB = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    noc_local_ingress_port_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ci;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == c_full);
    assign w_empty = (r_count == '0);
    // Fullness is judged on the pre-edge count: a same-cycle pop does not
    // make room for an arriving flit.
    assign w_push  = bus.in_valid && !w_full;
    assign w_drop  = bus.in_valid &&  w_full;
    assign w_pop   = !w_empty && bus.flit_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.datain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ci       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            r_ci       <= w_pop;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign bus.flit_out   = r_mem[r_rd_ptr];
    assign bus.flit_valid = !w_empty;
    assign bus.dest       = bus.flit_out[DEST_MSB:DEST_LSB];
    assign bus.count      = r_count;
    assign bus.ci         = r_ci;
    assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_noc_local_ingress_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_local_ingress_port
// Brief    : Directed + randomized bench against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_noc_local_ingress_port;
    localparam int DATA_W   = 20;
    localparam int DEPTH    = 8;
    localparam int DEST_MSB = 19;
    localparam int DEST_LSB = 16;
    localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_local_ingress_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W)) bus ();

    noc_local_ingress_port #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_MSB(DEST_MSB), .DEST_LSB(DEST_LSB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue plus expected ci/overflow.
    logic [DATA_W-1:0] m_q[$];
    logic              m_ci;
    logic              m_ov;
    logic [DATA_W-1:0] out_log[$];
    int                ci_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DATA_W-1:0] head;
        check_eq("count",      32'(bus.count),      32'(m_q.size()));
        check_eq("flit_valid", 32'(bus.flit_valid), 32'(m_q.size() != 0));
        check_eq("ci",         32'(bus.ci),         32'(m_ci));
        check_eq("overflow",   32'(bus.overflow),   32'(m_ov));
        if (m_q.size() != 0) begin
            head = m_q[0];
            check_eq("flit_out", 32'(bus.flit_out), 32'(head));
            check_eq("dest",     32'(bus.dest),     32'(head[DEST_MSB:DEST_LSB]));
        end
    endtask

    // Called at a falling edge: check current outputs, drive inputs, advance the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic pop;
        logic push;
        check_outputs();
        if (bus.ci) ci_seen++;
        bus.in_valid   = v;
        bus.datain     = d;
        bus.flit_ready = r;
        pop  = (m_q.size() != 0) && r;
        push = v && (m_q.size() < DEPTH);
        if (v && m_q.size() == DEPTH) m_ov = 1'b1;
        m_ci = pop;
        if (pop)  out_log.push_back(m_q.pop_front());
        if (push) m_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.flit_ready = 1'b0;
        bus.datain     = '0;
        #1;
        m_q.delete();
        m_ci = 1'b0;
        m_ov = 1'b0;
        check_eq("rst_count",    32'(bus.count),      32'd0);
        check_eq("rst_valid",    32'(bus.flit_valid), 32'd0);
        check_eq("rst_ci",       32'(bus.ci),         32'd0);
        check_eq("rst_overflow", 32'(bus.overflow),   32'd0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_log.delete();
        ci_seen = 0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    initial begin
        int credits;
        int sent;
        int returned;
        logic v;

        bus.in_valid = 1'b0; bus.flit_ready = 1'b0; bus.datain = '0;
        m_ci = 1'b0; m_ov = 1'b0; ci_seen = 0;
        @(negedge clk);
        do_reset(2);

        // Reset mid-traffic with three flits buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 20'(i + 32'h100), 1'b0);
        check_eq("t1_pre_count", 32'(bus.count), 32'd3);
        do_reset(2);
        idle(2, 1'b1);
        check_eq("t1_lost", 32'(out_log.size()), 32'd0);

        // Single flit.
        step(1'b1, 20'hA5123, 1'b1);
        check_eq("t2_flit_out", 32'(bus.flit_out), 32'hA5123);
        check_eq("t2_dest",     32'(bus.dest),     32'hA);
        check_eq("t2_ci_early", 32'(bus.ci),       32'd0);
        step(1'b0, '0, 1'b1);
        check_eq("t2_ci_pulse", 32'(bus.ci),       32'd1);
        idle(2, 1'b1);

        // Fill, overflow, drain.
        do_reset(1);
        for (int i = 1; i <= 8; i++) step(1'b1, 20'(i), 1'b0);
        check_eq("t3_full", 32'(bus.count), 32'd8);
        step(1'b1, 20'd9, 1'b0);
        check_eq("t3_ovf",       32'(bus.overflow), 32'd1);
        check_eq("t3_full_hold", 32'(bus.count),    32'd8);
        idle(10, 1'b1);
        check_eq("t3_drained", 32'(out_log.size()), 32'd8);
        check_eq("t3_ci_cnt",  32'(ci_seen),        32'd8);
        for (int i = 0; i < out_log.size(); i++)
            check_eq("t3_order", 32'(out_log[i]), 32'(i + 1));

        // Concurrent push and pop at count=3.
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 20'(32'h200 + i), 1'b0);
        for (int i = 3; i < 13; i++) begin
            step(1'b1, 20'(32'h200 + i), 1'b1);
            check_eq("t4_count", 32'(bus.count), 32'd3);
        end
        idle(1, 1'b0);
        check_eq("t4_ci_cnt", 32'(ci_seen), 32'd10);
        for (int i = 0; i < out_log.size(); i++)
            check_eq("t4_order", 32'(out_log[i]), 32'(32'h200 + i));

        // Full-rate stream, pointers wrap.
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, 20'(32'h300 + i), 1'b1);
        idle(3, 1'b1);
        check_eq("t5_delivered", 32'(out_log.size()), 32'd20);
        check_eq("t5_overflow",  32'(bus.overflow),   32'd0);
        for (int i = 0; i < out_log.size(); i++)
            check_eq("t5_order", 32'(out_log[i]), 32'(32'h300 + i));

        // Credit-loop PE with 7 credits, crossbar ready toggling.
        do_reset(1);
        credits = 7; sent = 0; returned = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.ci) begin credits++; returned++; end
            v = (credits > 0);
            if (v) begin credits--; sent++; end
            step(v, 20'($urandom), 1'((i % 2) == 0));
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.ci) begin credits++; returned++; end
            step(1'b0, '0, 1'b1);
        end
        check_eq("t6_overflow", 32'(bus.overflow), 32'd0);
        check_eq("t6_credits",  32'(returned),     32'(sent));
        check_eq("t6_balance",  32'(credits),      32'd7);

        // Randomized traffic with occasional mid-stream resets.
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
            step(1'($urandom_range(0, 3) != 0), 20'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        idle(DEPTH + 2, 1'b1);
        check_eq("rand_empty", 32'(bus.flit_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
